// File: rtl/jamma_joy_if.sv
// JAMMA joystick multiplex bundle: host select strobe, raw contacts in, muxed bus and debounced bytes out.
interface jamma_joy_if;
    logic       JSELECT;
    logic [7:0] p1_raw;
    logic [7:0] p2_raw;
    logic [7:0] JJOY;
    logic [7:0] p1_state;
    logic [7:0] p2_state;
    logic       sel_alive;

    modport master (
        output JSELECT, p1_raw, p2_raw,
        input  JJOY, p1_state, p2_state, sel_alive
    );

    modport slave (
        input  JSELECT, p1_raw, p2_raw,
        output JJOY, p1_state, p2_state, sel_alive
    );
endinterface

// File: rtl/jamma_joy_responder.sv
// Board-side JAMMA joystick responder: per-bit debounce of both players, select watchdog,
// and a same-cycle select mux onto the shared active-low bus.
module jamma_joy_responder #(
    parameter int unsigned DEBOUNCE_W = 4,
    parameter int unsigned WATCHDOG   = 64,
    parameter bit          SWAP       = 1'b0
) (
    input  logic        pclk,
    input  logic        reset_n,
    jamma_joy_if.slave  bus
);

    localparam int unsigned NBITS = 16;
    // A zero-width filter keeps a 1-bit counter pinned at zero, so every mismatch is taken at once.
    localparam int unsigned CNT_W = (DEBOUNCE_W == 0) ? 1 : DEBOUNCE_W;
    localparam int unsigned WD_W  = $clog2(WATCHDOG + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((64'd1 << DEBOUNCE_W) - 64'd1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(WATCHDOG);

    logic [NBITS-1:0]            raw_c;
    logic [NBITS-1:0]            state_q, state_d;
    logic [NBITS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                        sel_prev_q, sel_prev_d;
    logic [WD_W-1:0]             wd_q, wd_d;
    logic                        sel_alive_q, sel_alive_d;
    logic                        sel_b_c;

    assign raw_c = {bus.p2_raw, bus.p1_raw};

    // Per-bit stability counters: any agreeing cycle restarts the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < NBITS; i++) begin
            if (raw_c[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                state_d[i] = raw_c[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Select-edge watchdog; saturates at WATCHDOG with the bus forced idle.
    always_comb begin
        sel_prev_d  = bus.JSELECT;
        wd_d        = wd_q;
        sel_alive_d = sel_alive_q;
        if (bus.JSELECT != sel_prev_q) begin
            wd_d        = '0;
            sel_alive_d = 1'b1;
        end else if (wd_q != WD_MAX) begin
            wd_d        = wd_q + WD_W'(1);
            sel_alive_d = ((wd_q + WD_W'(1)) != WD_MAX);
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= '1;
            cnt_q       <= '0;
            sel_prev_q  <= 1'b0;
            wd_q        <= WD_MAX;
            sel_alive_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_prev_q  <= sel_prev_d;
            wd_q        <= wd_d;
            sel_alive_q <= sel_alive_d;
        end
    end

    // The host samples in the cycle it drives select, so only the mux sits on this path.
    assign sel_b_c = bus.JSELECT ^ SWAP;

    assign bus.JJOY      = !sel_alive_q ? 8'hFF : (sel_b_c ? state_q[15:8] : state_q[7:0]);
    assign bus.p1_state  = state_q[7:0];
    assign bus.p2_state  = state_q[15:8];
    assign bus.sel_alive = sel_alive_q;

endmodule

// File: tb/tb_jamma_joy_responder.sv
// Scoreboarded bench: a default-parameter instance and a SWAP=1 / DEBOUNCE_W=0 / WATCHDOG=4 instance.
module tb_jamma_joy_responder;

    logic pclk = 1'b0;
    logic reset_n = 1'b0;
    always #5 pclk = ~pclk;

    jamma_joy_if ja ();
    jamma_joy_if jb ();

    jamma_joy_responder u_a (
        .pclk    (pclk),
        .reset_n (reset_n),
        .bus     (ja)
    );

    jamma_joy_responder #(
        .DEBOUNCE_W (0),
        .WATCHDOG   (4),
        .SWAP       (1'b1)
    ) u_b (
        .pclk    (pclk),
        .reset_n (reset_n),
        .bus     (jb)
    );

    typedef struct {
        string      name;
        bit         dut;
        logic [7:0] ej;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       ea;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       sel;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       ea;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic sel_v;

    task automatic chk8(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h want %h at %0t", nm, fld, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input string fld, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %b want %b at %0t", nm, fld, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus before the edge and queue what must be visible just after it.
    task automatic step(input string nm, input bit dut, input logic rst, input logic sel,
                        input logic [7:0] r1, input logic [7:0] r2,
                        input logic [7:0] e1, input logic [7:0] e2, input logic ea);
        exp_t e;
        logic sw;
        @(negedge pclk);
        reset_n = rst;
        if (dut == 1'b0) begin
            ja.JSELECT = sel; ja.p1_raw = r1; ja.p2_raw = r2;
        end else begin
            jb.JSELECT = sel; jb.p1_raw = r1; jb.p2_raw = r2;
        end
        sw     = dut;
        e.name = nm;
        e.dut  = dut;
        e.e1   = e1;
        e.e2   = e2;
        e.ea   = ea;
        e.ej   = !ea ? 8'hFF : ((sel ^ sw) ? e2 : e1);
        sb_q.push_back(e);
    endtask

    exp_t cur;
    always @(posedge pclk) begin
        #1;
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            if (cur.dut == 1'b0) begin
                chk8(cur.name, "JJOY", ja.JJOY, cur.ej);
                chk8(cur.name, "p1_state", ja.p1_state, cur.e1);
                chk8(cur.name, "p2_state", ja.p2_state, cur.e2);
                chk1(cur.name, "sel_alive", ja.sel_alive, cur.ea);
            end else begin
                chk8(cur.name, "JJOY", jb.JJOY, cur.ej);
                chk8(cur.name, "p1_state", jb.p1_state, cur.e1);
                chk8(cur.name, "p2_state", jb.p2_state, cur.e2);
                chk1(cur.name, "sel_alive", jb.sel_alive, cur.ea);
            end
        end
    end

    initial begin
        vec_t v;
        ja.JSELECT = 1'b0; ja.p1_raw = 8'h00; ja.p2_raw = 8'hFF;
        jb.JSELECT = 1'b0; jb.p1_raw = 8'hFF; jb.p2_raw = 8'hFF;

        // Reset held with p1 contacts closed, then 20 idle cycles, then the mux run.
        for (int i = 0; i < 3; i++) begin
            v = '{rst: 1'b0, sel: 1'b0, r1: 8'h00, r2: 8'hFF, e1: 8'hFF, e2: 8'hFF, ea: 1'b0};
            vecs.push_back(v);
        end
        for (int i = 0; i < 20; i++) begin
            v = '{rst: 1'b1, sel: 1'b0, r1: 8'hFF, r2: 8'hFF, e1: 8'hFF, e2: 8'hFF, ea: 1'b0};
            vecs.push_back(v);
        end
        for (int i = 1; i <= 24; i++) begin
            v.rst = 1'b1;
            v.sel = (i % 2 == 1);
            v.r1  = 8'hFE;
            v.r2  = 8'h7F;
            v.e1  = (i >= 16) ? 8'hFE : 8'hFF;
            v.e2  = (i >= 16) ? 8'h7F : 8'hFF;
            v.ea  = 1'b1;
            vecs.push_back(v);
        end
        foreach (vecs[k])
            step("vec", 1'b0, vecs[k].rst, vecs[k].sel, vecs[k].r1, vecs[k].r2,
                 vecs[k].e1, vecs[k].e2, vecs[k].ea);
        sel_v = 1'b0;

        // Player 2 released, then a 15-cycle glitch, then a 16-cycle hold.
        for (int i = 1; i <= 16; i++) begin
            sel_v = ~sel_v;
            step("p2_release", 1'b0, 1'b1, sel_v, 8'hFE, 8'hFF, 8'hFE, (i >= 16) ? 8'hFF : 8'h7F, 1'b1);
        end
        for (int i = 1; i <= 15; i++) begin
            sel_v = ~sel_v;
            step("glitch15", 1'b0, 1'b1, sel_v, 8'hFE, 8'hBF, 8'hFE, 8'hFF, 1'b1);
        end
        for (int i = 1; i <= 5; i++) begin
            sel_v = ~sel_v;
            step("glitch_end", 1'b0, 1'b1, sel_v, 8'hFE, 8'hFF, 8'hFE, 8'hFF, 1'b1);
        end
        for (int i = 1; i <= 18; i++) begin
            sel_v = ~sel_v;
            step("hold16", 1'b0, 1'b1, sel_v, 8'hFE, 8'hBF, 8'hFE, (i >= 16) ? 8'hBF : 8'hFF, 1'b1);
        end

        // Watchdog: last change to 1, freeze, expect the drop on the 64th edge.
        if (sel_v == 1'b1) begin
            sel_v = 1'b0;
            step("wd_pre", 1'b0, 1'b1, sel_v, 8'hFE, 8'hBF, 8'hFE, 8'hBF, 1'b1);
        end
        sel_v = 1'b1;
        step("wd_last", 1'b0, 1'b1, sel_v, 8'hFE, 8'hBF, 8'hFE, 8'hBF, 1'b1);
        for (int k = 1; k <= 70; k++)
            step("wd_freeze", 1'b0, 1'b1, 1'b1, 8'hFE, 8'hBF, 8'hFE, 8'hBF, (k < 64));
        step("wd_resume", 1'b0, 1'b1, 1'b0, 8'hFE, 8'hBF, 8'hFE, 8'hBF, 1'b1);
        step("wd_resume2", 1'b0, 1'b1, 1'b1, 8'hFE, 8'hBF, 8'hFE, 8'hBF, 1'b1);
        sel_v = 1'b1;

        // Reset in the middle of a debounce count discards the partial count.
        for (int i = 1; i <= 10; i++) begin
            sel_v = ~sel_v;
            step("rmc_pre", 1'b0, 1'b1, sel_v, 8'h00, 8'hBF, 8'hFE, 8'hBF, 1'b1);
        end
        step("rmc_reset", 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        for (int i = 1; i <= 20; i++)
            step("rmc_post", 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, (i >= 16) ? 8'h00 : 8'hFF, 8'hFF, 1'b0);

        // Swapped, unfiltered instance: single-edge updates and a 4-edge watchdog.
        for (int i = 1; i <= 6; i++)
            step("swap", 1'b1, 1'b1, (i % 2 == 1), 8'h01, 8'h02, 8'h01, 8'h02, 1'b1);
        step("nofilter", 1'b1, 1'b1, 1'b1, 8'h03, 8'h02, 8'h03, 8'h02, 1'b1);
        step("nofilter2", 1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 8'h01, 8'h02, 1'b1);
        for (int k = 1; k <= 6; k++)
            step("swap_wd", 1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 8'h01, 8'h02, (k < 4));

        @(negedge pclk);
        @(negedge pclk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
